// File: rtl/i2c_target_regs_if.sv
// Bus-side and local-side signals of the I2C register target, grouped so the
// target and its surroundings can be connected through a single port.
`timescale 1ns/1ps
interface i2c_target_regs_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_valid;
    logic [3:0] wr_reg;
    logic [7:0] wr_data;
    logic [3:0] host_addr;
    logic [7:0] host_rdata;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, host_addr,
        output sda_oe, wr_valid, wr_reg, wr_data, host_rdata, busy
    );

    modport master (
        output scl_i, sda_i, host_addr,
        input  sda_oe, wr_valid, wr_reg, wr_data, host_rdata, busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file behind an auto-incrementing
// pointer; reports bus writes and offers a local combinational read port.
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         HOLD_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    i2c_target_regs_if.slave bus
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t state, state_nxt;

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;
    logic scl_rise, scl_fall, bus_start, bus_stop;

    logic [3:0]        bit_cnt;
    logic [6:0]        rx_sh;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_sh;
    logic [3:0]        ptr;
    logic [3:0]        ptr_rd;
    logic [7:0]        regs [16];
    logic              rw;
    logic              busy_q, busy_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_hit;
    logic              sda_oe_q;
    logic              wr_valid_q;
    logic [3:0]        wr_reg_q;
    logic [7:0]        wr_data_q;

    logic cnt_clr, addr_hit, ptr_ld, ptr_inc, byte_wr, tx_ld, sda_want;

    // p0/p1: synchronizer, p2: history for edge decode
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
            sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= bus.scl_i; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
            sda_p0 <= bus.sda_i; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign bus_start = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign bus_stop  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
    assign rx_byte   = {rx_sh, sda_p1};
    assign hold_hit  = (hold_cnt == HOLD_W'(1));
    assign ptr_rd    = ptr + {3'b000, ptr_inc};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // bit_cnt reaches 9 on the ACK-slot rise; the following fall ends the slot
    always_comb begin
        state_nxt = state;
        busy_nxt  = busy_q;
        cnt_clr   = 1'b0;
        addr_hit  = 1'b0;
        ptr_ld    = 1'b0;
        ptr_inc   = 1'b0;
        byte_wr   = 1'b0;
        tx_ld     = 1'b0;
        sda_want  = 1'b0;
        case (state)
            ADDR: if (scl_rise && bit_cnt == 4'd7) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                    state_nxt = ADDR_ACK;
                    addr_hit  = 1'b1;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IGNORE;
                    busy_nxt  = 1'b0;
                end
            end
            ADDR_ACK: begin
                sda_want = 1'b1;
                if (scl_fall && bit_cnt == 4'd9) begin
                    cnt_clr = 1'b1;
                    if (rw) begin
                        state_nxt = RDATA;
                        tx_ld     = 1'b1;
                    end else begin
                        state_nxt = PTR;
                    end
                end
            end
            PTR: if (scl_rise && bit_cnt == 4'd7) begin
                ptr_ld    = 1'b1;
                state_nxt = PTR_ACK;
            end
            PTR_ACK, WDATA_ACK: begin
                sda_want = 1'b1;
                if (scl_fall && bit_cnt == 4'd9) begin
                    cnt_clr   = 1'b1;
                    state_nxt = WDATA;
                end
            end
            WDATA: if (scl_rise && bit_cnt == 4'd7) begin
                byte_wr   = 1'b1;
                state_nxt = WDATA_ACK;
            end
            RDATA: begin
                sda_want = ~tx_sh[7];
                if (scl_rise && bit_cnt == 4'd7) state_nxt = RACK;
            end
            RACK: if (scl_rise) begin
                cnt_clr = 1'b1;
                ptr_inc = 1'b1;
                if (!sda_p1) begin
                    tx_ld     = 1'b1;
                    state_nxt = RDATA;
                end else begin
                    state_nxt = IGNORE;
                end
            end
            default: ;
        endcase
        if (bus_stop) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
        end else if (bus_start) begin
            state_nxt = ADDR;
            cnt_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (scl_rise) rx_sh <= rx_byte[6:0];
        if (tx_ld)
            tx_sh <= regs[ptr_rd];
        else if (scl_rise && state == RDATA)
            tx_sh <= {tx_sh[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            ptr        <= 4'd0;
            rw         <= 1'b0;
            busy_q     <= 1'b0;
            hold_cnt   <= '0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_reg_q   <= 4'd0;
            wr_data_q  <= 8'h00;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            busy_q     <= busy_nxt;
            wr_valid_q <= 1'b0;
            if (cnt_clr)       bit_cnt <= 4'd0;
            else if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (addr_hit) rw <= rx_byte[0];
            if (byte_wr) begin
                regs[ptr]  <= rx_byte;
                wr_valid_q <= 1'b1;
                wr_reg_q   <= ptr;
                wr_data_q  <= rx_byte;
            end
            if (ptr_ld)                 ptr <= rx_byte[3:0];
            else if (byte_wr | ptr_inc) ptr <= ptr + 4'd1;
            if (scl_fall)              hold_cnt <= HOLD_W'(HOLD_CYCLES);
            else if (hold_cnt != '0)   hold_cnt <= hold_cnt - HOLD_W'(1);
            // SDA only moves once the hold time after SCL fall has elapsed
            if (bus_start | bus_stop) sda_oe_q <= 1'b0;
            else if (hold_hit)        sda_oe_q <= sda_want;
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_reg     = wr_reg_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.host_rdata = regs[bus.host_addr];
endmodule
